cfg_bus_master: RTL
===================

// Module: cfg_bus_master
// PURPOSE
//  Initiator for the switch's cfg register bus (cfg_cs_n/cfg_ack_n/cfg_rw/cfg_addr/
//  cfg_wdata/cfg_rdata), the side that the um datapath responds to.
//  Turns single read/write commands from a valid/ready command port into
//  four-phase cfg transactions.
//  Returns read data and an error flag on a valid/ready response port.
//  Bounds every phase with a timeout so a dead responder cannot hang the controller.
// PARAMETERS
//  TIMEOUT   1024  max cycles spent in REQ or in REL (must be >=2)
//  CNT_W     16    width of timeout counter and timeout_cnt (must hold TIMEOUT)
// PORTS
//  clk          in   1   single clock
//  rst          in   1   synchronous reset, active-high
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   command accepted when cmd_valid&cmd_ready
//  cmd_rw       in   1   0 write, 1 read
//  cmd_addr     in   32  register address
//  cmd_wdata    in   32  write data (ignored for reads)
//  rsp_valid    out  1   response available
//  rsp_ready    in   1   response consumed when rsp_valid&rsp_ready
//  rsp_rdata    out  32  read data (0 for writes and on error)
//  rsp_err      out  1   1 = transaction timed out
//  cfg_cs_n     out  1   chip select, low active
//  cfg_ack_n    in   1   responder ack, low active
//  cfg_rw       out  1   0 write, 1 read
//  cfg_addr     out  32  address
//  cfg_wdata    out  32  write data
//  cfg_rdata    in   32  read data, valid in the cycle cfg_ack_n is low
//  busy         out  1   state != IDLE
//  timeout_cnt  out  CNT_W  count of timed-out transactions, saturating
// BEHAVIOUR
//  Reset values
//   - state = IDLE, cfg_cs_n = 1, cfg_rw/cfg_addr/cfg_wdata = 0
//   - cmd_ready = 0 during reset, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
//   - busy = 0, timeout_cnt = 0
//  Outputs: all outputs are registered except cmd_ready and busy, which decode state.
//  Reset mid-transaction: any state goes to IDLE next cycle, cfg_cs_n goes high,
//   and the pending response is dropped.
//  IDLE
//   - cmd_ready = 1.
//   - On handshake, latch rw/addr/wdata onto cfg_*, drive cfg_cs_n = 0 from the next
//     cycle, clear the counter, and go to REQ.
//  REQ (cs_n low)
//   - cfg_rw/addr/wdata are held stable.
//   - If cfg_ack_n = 0: capture rdata (cfg_rdata if read, else 0), set err = 0, drive
//     cs_n = 1 next cycle, clear the counter, and go to REL.
//   - Else the counter increments. When the counter = TIMEOUT-1 and ack_n is still 1:
//     set err = 1, rdata = 0, cs_n = 1 next cycle, clear the counter, go to REL, and
//     increment timeout_cnt.
//   - Result: cs_n is low for exactly N cycles if ack arrives in the Nth low cycle,
//     or TIMEOUT cycles on timeout.
//  REL (cs_n high)
//   - Wait for cfg_ack_n = 1, then go to RSP.
//   - If ack_n stays low for TIMEOUT cycles: set err = 1, increment timeout_cnt once
//     for the transaction (not twice), and go to RSP.
//   - A late ack in REL after a REQ timeout is ignored and is not captured.
//  RSP
//   - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
//   - On rsp_ready, go to IDLE with rsp_valid = 0 next cycle.
//   - There is no response/command overlap: the next cmd_ready occurs no earlier than
//     the cycle after the response handshake.
//  Latency and limits
//   - Minimum command-to-response latency: accept at T, cs_n low T+1, ack at T+1,
//     REL T+2 (ack_n already high), rsp_valid at T+3.
//   - ack_n low while in IDLE or RSP is ignored.
//   - timeout_cnt saturates at all-ones.
// TESTING
//  1. Write addr 0x10 data 0xDEADBEEF, with ack_n low on the 3rd cs_n-low cycle:
//     - cs_n low exactly 3 cycles, cfg_rw = 0, cfg_addr/cfg_wdata stable
//     - rsp_err = 0, rsp_rdata = 0
//  2. Read addr 0x20, with responder returning 0x12345678 with ack on the 1st cycle:
//     - rsp_rdata = 0x12345678, rsp_err = 0
//     - rsp_valid 3 cycles after cmd accept
//  3. TIMEOUT=16, responder never acks:
//     - cs_n low exactly 16 cycles
//     - rsp_err = 1, rsp_rdata = 0, timeout_cnt = 1
//  4. Hold rsp_ready low for 5 cycles after rsp_valid:
//     - rsp held stable, cmd_ready = 0 throughout
//     - release -> IDLE next cycle
//  5. Assert rst in the 2nd REQ cycle:
//     - cfg_cs_n = 1 and busy = 0 the next cycle, no rsp_valid
//     - next command works normally
//  6. Hold ack_n low after ack for TIMEOUT cycles:
//     - REL times out, rsp_err = 1, rdata of the read is discarded as 0
//     - timeout_cnt increments by 1

Source files
------------

// File: rtl/cfg_bus_master.sv
// Initiator for the cfg register bus. It turns valid/ready commands into four-phase
// cs_n/ack_n transactions, bounds each phase with a timeout, and returns a response.
module cfg_bus_master #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             cfg_cs_n,
  input  logic             cfg_ack_n,
  output logic             cfg_rw,
  output logic [31:0]      cfg_addr,
  output logic [31:0]      cfg_wdata,
  input  logic [31:0]      cfg_rdata,
  output logic             busy,
  output logic [CNT_W-1:0] timeout_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, REL, RSP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             req_timed_out;
  logic             cmd_hs, req_ack, req_to, rel_done, rel_to, tcnt_inc;

  always_comb begin
    cmd_hs   = cmd_valid && cmd_ready;
    req_ack  = (state == REQ) && !cfg_ack_n;
    req_to   = (state == REQ) && cfg_ack_n && (cnt == CNT_LAST);
    rel_done = (state == REL) && cfg_ack_n;
    rel_to   = (state == REL) && !cfg_ack_n && (cnt == CNT_LAST);
    // A transaction whose REQ already timed out must not be counted again in REL
    tcnt_inc = req_to || (rel_to && !req_timed_out);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cmd_hs)              state_nxt = REQ;
      REQ:  if (req_ack || req_to)   state_nxt = REL;
      REL:  if (rel_done || rel_to)  state_nxt = RSP;
      RSP:  if (rsp_ready)           state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE) && !rst;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_cs_n      <= 1'b1;
      cfg_rw        <= 1'b0;
      cfg_addr      <= '0;
      cfg_wdata     <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      cnt           <= '0;
      req_timed_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (cmd_hs) begin
          cfg_rw    <= cmd_rw;
          cfg_addr  <= cmd_addr;
          cfg_wdata <= cmd_wdata;
          cfg_cs_n  <= 1'b0;
          cnt       <= '0;
        end
        REQ: begin
          if (req_ack) begin
            rsp_rdata     <= cfg_rw ? cfg_rdata : '0;
            rsp_err       <= 1'b0;
            cfg_cs_n      <= 1'b1;
            cnt           <= '0;
            req_timed_out <= 1'b0;
          end else if (req_to) begin
            rsp_rdata     <= '0;
            rsp_err       <= 1'b1;
            cfg_cs_n      <= 1'b1;
            cnt           <= '0;
            req_timed_out <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REL: begin
          if (rel_to) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
          end else if (rel_done) begin
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RSP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                            timeout_cnt <= '0;
    else if (tcnt_inc && timeout_cnt != '1) timeout_cnt <= timeout_cnt + CNT_W'(1);
  end

endmodule
